spcpu_mem_responder: RTL and testbench

Synthesizable memory-side responder for the SPCPU memory bus. It answers `spcpu` read/write requests on `req_rdwr` using a byte-addressed internal RAM, with configurable wait states and 8/16-bit access. It replaces the simulation-only memory model on the FPGA build and sits directly between the `spcpu` bus ports and on-chip block RAM.

---
 rtl/spcpu_mem_responder_if.sv | 21 ++
 rtl/spcpu_mem_responder.sv | 83 ++++++++
 tb/tb_spcpu_mem_responder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/spcpu_mem_responder_if.sv
// spcpu_mem_responder_if: SPCPU memory bus between the CPU (master) and the memory responder (slave)
interface spcpu_mem_responder_if #(parameter int ADDR_WIDTH = 16);
  logic                  req_rdwr;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic                  data_acc_sz;
  logic                  data_inout_we;
  logic [7:0]            write_data_in_8;
  logic [15:0]           write_data_in_16;
  logic [7:0]            read_data_out_8;
  logic [15:0]           read_data_out_16;
  logic                  data_ready;
  logic                  misalign;
  modport master (
    output req_rdwr, addr_in, data_acc_sz, data_inout_we, write_data_in_8, write_data_in_16,
    input  read_data_out_8, read_data_out_16, data_ready, misalign
  );
  modport slave (
    input  req_rdwr, addr_in, data_acc_sz, data_inout_we, write_data_in_8, write_data_in_16,
    output read_data_out_8, read_data_out_16, data_ready, misalign
  );
endinterface

// File: rtl/spcpu_mem_responder.sv
// spcpu_mem_responder: byte-addressed RAM answering SPCPU bus requests with wait states and 8/16-bit access
module spcpu_mem_responder #(
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_STATES = 2
) (
  input logic                  clk,
  input logic                  reset,
  spcpu_mem_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;
  state_t                state_q;
  logic [3:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  sz_q, we_q;
  logic [7:0]            wd8_q, rd8_q;
  logic [15:0]           wd16_q, rd16_q;
  logic                  rdy_q, mis_q;
  logic [7:0]            mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] lo_a, hi_a;
  assign lo_a = {addr_q[ADDR_WIDTH-1:1], 1'b0};
  assign hi_a = {addr_q[ADDR_WIDTH-1:1], 1'b1};
  assign bus.read_data_out_8  = rd8_q;
  assign bus.read_data_out_16 = rd16_q;
  assign bus.data_ready       = rdy_q;
  assign bus.misalign         = mis_q;
  // RAM commit happens only on the ACCESS edge; contents survive reset
  always_ff @(posedge clk) begin
    if (state_q == ACCESS && we_q) begin
      if (sz_q) begin
        mem[lo_a] <= wd16_q[7:0];
        mem[hi_a] <= wd16_q[15:8];
      end else begin
        mem[addr_q] <= wd8_q;
      end
    end
  end
  // Request FSM: latch in IDLE, count wait states, access once, hold DONE until req drops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      sz_q    <= 1'b0;
      we_q    <= 1'b0;
      wd8_q   <= 8'h00;
      wd16_q  <= 16'h0000;
      rd8_q   <= 8'h00;
      rd16_q  <= 16'h0000;
      rdy_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_rdwr) begin
          addr_q  <= bus.addr_in;
          sz_q    <= bus.data_acc_sz;
          we_q    <= bus.data_inout_we;
          wd8_q   <= bus.write_data_in_8;
          wd16_q  <= bus.write_data_in_16;
          cnt_q   <= 4'(WAIT_STATES);
          state_q <= (WAIT_STATES == 0) ? ACCESS : WAIT;
        end
        WAIT: if (!bus.req_rdwr) begin
          state_q <= IDLE;
        end else begin
          cnt_q   <= cnt_q - 4'd1;
          state_q <= (cnt_q == 4'd1) ? ACCESS : WAIT;
        end
        ACCESS: begin
          if (!we_q && sz_q) rd16_q <= {mem[hi_a], mem[lo_a]};
          if (!we_q && !sz_q) rd8_q <= mem[addr_q];
          mis_q   <= sz_q & addr_q[0];
          rdy_q   <= 1'b1;
          state_q <= DONE;
        end
        DONE: if (!bus.req_rdwr) begin
          rdy_q   <= 1'b0;
          mis_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spcpu_mem_responder.sv
// tb_spcpu_mem_responder: two responders (WAIT_STATES=2 and 0) checked every cycle against a transaction-level model
module tb_spcpu_mem_responder;
  logic        clk;
  logic        rst [2];
  logic        req [2], we [2], sz [2];
  logic [15:0] addr [2], wd16 [2];
  logic [7:0]  wd8 [2];
  logic        rdy [2], mis [2];
  logic [7:0]  rd8 [2];
  logic [15:0] rd16 [2];
  logic        e_rdy [2], e_mis [2];
  logic [7:0]  e_rd8 [2];
  logic [15:0] e_rd16 [2];
  logic        seen_mis [2];
  logic [7:0]  mm [int];
  int          n_tests, n_fail;
  bit          chk_en;

  for (genvar g = 0; g < 2; g++) begin : u
    spcpu_mem_responder_if #(.ADDR_WIDTH(16)) bus ();
    assign bus.req_rdwr         = req[g];
    assign bus.addr_in          = addr[g];
    assign bus.data_acc_sz      = sz[g];
    assign bus.data_inout_we    = we[g];
    assign bus.write_data_in_8  = wd8[g];
    assign bus.write_data_in_16 = wd16[g];
    assign rdy[g]               = bus.data_ready;
    assign mis[g]               = bus.misalign;
    assign rd8[g]               = bus.read_data_out_8;
    assign rd16[g]              = bus.read_data_out_16;
    spcpu_mem_responder #(.ADDR_WIDTH(16), .WAIT_STATES(g == 0 ? 2 : 0)) dut (
      .clk(clk), .reset(rst[g]), .bus(bus)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ws(int d);
    return d == 0 ? 2 : 0;
  endfunction

  function automatic int key(int d, logic [15:0] a);
    return d * 65536 + int'(a);
  endfunction

  function automatic logic [7:0] rdm(int d, logic [15:0] a);
    return mm.exists(key(d, a)) ? mm[key(d, a)] : 8'hxx;
  endfunction

  task automatic chk(string nm, int d, logic [15:0] act, logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Every falling edge: all DUT outputs must match what the model says they are now
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk("data_ready", d, {15'b0, rdy[d]}, {15'b0, e_rdy[d]});
        chk("misalign", d, {15'b0, mis[d]}, {15'b0, e_mis[d]});
        chk("read_data_out_8", d, {8'b0, rd8[d]}, {8'b0, e_rd8[d]});
        chk("read_data_out_16", d, rd16[d], e_rd16[d]);
      end
    end
  end

  // One CPU transaction, started at posedge+1; completion is predicted at edge WAIT_STATES+2
  task automatic xact(int d, bit w, bit s, logic [15:0] a, logic [7:0] v8, logic [15:0] v16,
                      int hold, int abort_at, bit scram);
    req[d] = 1'b1; we[d] = w; sz[d] = s; addr[d] = a; wd8[d] = v8; wd16[d] = v16;
    for (int k = 1; k <= ws(d) + 2; k++) begin
      @(posedge clk); #1;
      if (scram) begin
        addr[d] = 16'($urandom); wd8[d] = 8'($urandom); wd16[d] = 16'($urandom);
        we[d] = 1'($urandom); sz[d] = 1'($urandom);
      end
      if (k == abort_at) begin
        req[d] = 1'b0;
        @(posedge clk); #1;
        return;
      end
      if (k == ws(d) + 2) begin
        if (w && s) begin
          mm[key(d, a & 16'hFFFE)] = v16[7:0];
          mm[key(d, a | 16'h0001)] = v16[15:8];
        end else if (w) begin
          mm[key(d, a)] = v8;
        end else if (s) begin
          e_rd16[d] = {rdm(d, a | 16'h0001), rdm(d, a & 16'hFFFE)};
        end else begin
          e_rd8[d] = rdm(d, a);
        end
        e_rdy[d] = 1'b1;
        e_mis[d] = s & a[0];
        seen_mis[d] = mis[d];
      end
    end
    repeat (hold) begin
      wd8[d] = v8 ^ 8'h33;
      @(posedge clk); #1;
    end
    req[d] = 1'b0;
    @(posedge clk); #1;
    e_rdy[d] = 1'b0;
    e_mis[d] = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; chk_en = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0; sz[d] = 1'b0;
      addr[d] = '0; wd8[d] = '0; wd16[d] = '0;
      e_rdy[d] = 1'b0; e_mis[d] = 1'b0; e_rd8[d] = '0; e_rd16[d] = '0; seen_mis[d] = 1'b0;
    end
    #1 rst[0] = 1'b1; rst[1] = 1'b1;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst[0] = 1'b0; rst[1] = 1'b0;
    @(posedge clk); #1;
    // WAIT_STATES=2: little-endian 16-bit write, byte reads
    xact(0, 1, 1, 16'h0100, 8'h00, 16'hBEEF, 0, 0, 0);
    xact(0, 0, 0, 16'h0100, 8'h00, 16'h0000, 0, 0, 0);
    chk("beef_lo", 0, {8'b0, rd8[0]}, 16'h00EF);
    chk("model_beef_lo", 0, {8'b0, e_rd8[0]}, 16'h00EF);
    xact(0, 0, 0, 16'h0101, 8'h00, 16'h0000, 0, 0, 0);
    chk("beef_hi", 0, {8'b0, rd8[0]}, 16'h00BE);
    // Aborted write leaves prior contents
    xact(0, 1, 1, 16'h0300, 8'h00, 16'h0000, 0, 0, 0);
    xact(0, 1, 1, 16'h0300, 8'h00, 16'hAAAA, 0, 2, 0);
    xact(0, 0, 1, 16'h0300, 8'h00, 16'h0000, 0, 0, 0);
    chk("abort_read", 0, rd16[0], 16'h0000);
    // Long hold in DONE with changing write data: single commit
    xact(0, 1, 0, 16'h0600, 8'h55, 16'h0000, 10, 0, 0);
    xact(0, 0, 1, 16'h0100, 8'h00, 16'h0000, 0, 0, 0);
    xact(0, 0, 0, 16'h0600, 8'h00, 16'h0000, 0, 0, 0);
    chk("hold_single_write", 0, {8'b0, rd8[0]}, 16'h0055);
    chk("pre_reset_rd16", 0, rd16[0], 16'hBEEF);
    // Asynchronous reset in the middle of a write's WAIT
    xact(0, 1, 1, 16'h0500, 8'h00, 16'h0000, 0, 0, 0);
    req[0] = 1'b1; we[0] = 1'b1; sz[0] = 1'b1; addr[0] = 16'h0500; wd16[0] = 16'h7777;
    @(posedge clk); #2;
    rst[0] = 1'b1; req[0] = 1'b0;
    e_rdy[0] = 1'b0; e_mis[0] = 1'b0; e_rd8[0] = 8'h00; e_rd16[0] = 16'h0000;
    #1;
    chk("async_rst_rd8", 0, {8'b0, rd8[0]}, 16'h0000);
    chk("async_rst_rd16", 0, rd16[0], 16'h0000);
    chk("async_rst_rdy", 0, {15'b0, rdy[0]}, 16'h0000);
    @(posedge clk); #1 rst[0] = 1'b0;
    xact(0, 0, 1, 16'h0500, 8'h00, 16'h0000, 0, 0, 0);
    chk("reset_no_commit", 0, rd16[0], 16'h0000);
    // WAIT_STATES=0: byte writes then word reads, aligned and misaligned
    xact(1, 1, 0, 16'h0200, 8'h12, 16'h0000, 0, 0, 0);
    xact(1, 1, 0, 16'h0201, 8'h34, 16'h0000, 0, 0, 0);
    xact(1, 0, 1, 16'h0200, 8'h00, 16'h0000, 0, 0, 0);
    chk("word_3412", 1, rd16[1], 16'h3412);
    chk("model_word_3412", 1, e_rd16[1], 16'h3412);
    chk("aligned_mis", 1, {15'b0, seen_mis[1]}, 16'h0000);
    xact(1, 0, 1, 16'h0201, 8'h00, 16'h0000, 0, 0, 0);
    chk("odd_word_3412", 1, rd16[1], 16'h3412);
    chk("odd_mis", 1, {15'b0, seen_mis[1]}, 16'h0001);
    chk("odd_rdy_clear", 1, {15'b0, rdy[1]}, 16'h0000);
    chk("odd_mis_clear", 1, {15'b0, mis[1]}, 16'h0000);
    // Randomized traffic inside a zero-filled window on both responders
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) xact(d, 1, 1, 16'h0400 + 16'(2 * i), 8'h00, 16'h0000, 0, 0, 0);
      for (int i = 0; i < 60; i++) begin
        automatic logic [15:0] a = 16'h0400 + 16'($urandom_range(0, 15));
        automatic int ab = (ws(d) > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(1, ws(d)) : 0;
        xact(d, 1'($urandom), 1'($urandom), a, 8'($urandom), 16'($urandom),
             $urandom_range(0, 3), ab, 1'($urandom));
      end
    end
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
